// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer: funct3 encodings, the
// per-entry payload, and byte-lane mask/placement functions.
package sb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Lane-placed payload; address word and ROB tag live in parameterised arrays.
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  // funct3[1:0] gives the access size for loads and stores alike.
  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_place(input logic [31:0] d, input logic [1:0] a,
                                             input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return d << {a, 3'b000};
      2'b01:   return d << {a[1], 4'b0000};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/sb_fwd_unit.sv
// Combinational store-to-load forwarding: per requested byte the youngest
// matching entry wins; the result is then shifted down and extended.
module sb_fwd_unit
  import sb_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                              ld_valid_i,
  input  logic [ADDR_W-1:0]                 ld_addr_i,
  input  logic [2:0]                        ld_funct3_i,
  input  logic [DEPTH-1:0]                  ent_vld_i,
  input  logic [DEPTH-1:0][ADDR_W-3:0]      ent_word_i,
  input  logic [DEPTH-1:0][31:0]            ent_data_i,
  input  logic [DEPTH-1:0][3:0]             ent_mask_i,
  output logic                              hit_o,
  output logic                              conflict_o,
  output logic [31:0]                       data_o
);

  logic [3:0]  req;
  logic [3:0]  got;
  logic [3:0]  cov;
  logic [31:0] fwd_word;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [1:0]  off;
  logic        all_cov;

  // Entries arrive oldest first (index 0), so later matches overwrite older ones.
  always_comb begin
    req      = byte_mask(ld_funct3_i, ld_addr_i[1:0]);
    got      = '0;
    fwd_word = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld_i[k] && (ent_word_i[k] == ld_addr_i[ADDR_W-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_mask_i[k][b]) begin
            got[b]            = 1'b1;
            fwd_word[8*b +: 8] = ent_data_i[k][8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    case (ld_funct3_i[1:0])
      2'b00:   off = ld_addr_i[1:0];
      2'b01:   off = {ld_addr_i[1], 1'b0};
      default: off = 2'b00;
    endcase
    shifted = fwd_word >> {off, 3'b000};
    case (ld_funct3_i)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ext = {24'h0, shifted[7:0]};
      F3_HU:   ext = {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign cov        = got & req;
  assign all_cov    = (cov == req);
  assign hit_o      = ld_valid_i && all_cov;
  assign conflict_o = ld_valid_i && (cov != 4'b0000) && !all_cov;
  assign data_o     = hit_o ? ext : 32'h0;

endmodule

// File: rtl/store_buffer_fwd.sv
// Speculative store buffer: holds stores until ROB commit, drains committed
// stores oldest-first to the D-cache, forwards to loads, discards on flush.
module store_buffer_fwd
  import sb_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 32,
  parameter int ROB_IDX_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [31:0]                  in_data,
  input  logic [2:0]                   in_funct3,
  input  logic [ROB_IDX_W-1:0]         in_rob_idx,
  output logic                         out_full,
  output logic                         out_empty,
  output logic [$clog2(DEPTH+1)-1:0]   out_count,
  input  logic                         in_commit_valid,
  input  logic [ROB_IDX_W-1:0]         in_commit_idx,
  input  logic                         in_flush,
  output logic                         out_drain_valid,
  output logic [ADDR_W-1:0]            out_drain_addr,
  output logic [31:0]                  out_drain_data,
  output logic [3:0]                   out_drain_mask,
  input  logic                         in_drain_ready,
  input  logic                         in_ld_valid,
  input  logic [ADDR_W-1:0]            in_ld_addr,
  input  logic [2:0]                   in_ld_funct3,
  output logic                         out_ld_hit,
  output logic [31:0]                  out_ld_data,
  output logic                         out_ld_conflict
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] cmt_cnt_q, cmt_cnt_d;
  logic [DEPTH-1:0] cmt_q, cmt_d;

  sb_entry_t            ent_q  [DEPTH];
  logic [ADDR_W-3:0]    word_q [DEPTH];
  logic [ROB_IDX_W-1:0] tag_q  [DEPTH];

  logic [PTR_W-1:0] occ;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             alloc, fire, cmt_hit;
  logic [IDX_W-1:0] cmt_sel;

  logic [IDX_W-1:0]                 age_idx [DEPTH];
  logic [DEPTH-1:0]                 age_vld;
  logic [DEPTH-1:0][ADDR_W-3:0]     age_word;
  logic [DEPTH-1:0][31:0]           age_data;
  logic [DEPTH-1:0][3:0]            age_mask;

  assign occ       = tail_q - head_q;
  assign head_idx  = head_q[IDX_W-1:0];
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign out_full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign out_empty = (head_q == tail_q);
  assign out_count = CNT_W'(occ);

  assign alloc           = in_valid && !out_full && !in_flush;
  assign out_drain_valid = !out_empty && cmt_q[head_idx];
  assign fire            = out_drain_valid && in_drain_ready;
  assign out_drain_addr  = out_drain_valid ? {word_q[head_idx], 2'b00} : '0;
  assign out_drain_data  = out_drain_valid ? ent_q[head_idx].data : '0;
  assign out_drain_mask  = out_drain_valid ? ent_q[head_idx].mask : '0;

  // Re-index the ring oldest-first so forwarding and commit search see age order.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k]  = head_idx + IDX_W'(k);
      age_vld[k]  = PTR_W'(k) < occ;
      age_word[k] = word_q[age_idx[k]];
      age_data[k] = ent_q[age_idx[k]].data;
      age_mask[k] = ent_q[age_idx[k]].mask;
    end
  end

  // Oldest uncommitted entry carrying the retired tag.
  always_comb begin
    cmt_hit = 1'b0;
    cmt_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (in_commit_valid && !cmt_hit && age_vld[k] && !cmt_q[age_idx[k]] &&
          (tag_q[age_idx[k]] == in_commit_idx)) begin
        cmt_hit = 1'b1;
        cmt_sel = age_idx[k];
      end
    end
  end

  // Flush keeps exactly the committed run from the current head, including this cycle's commit.
  always_comb begin
    head_d    = head_q + PTR_W'(fire);
    cmt_cnt_d = cmt_cnt_q + PTR_W'(cmt_hit) - PTR_W'(fire);
    if (in_flush) tail_d = head_q + cmt_cnt_q + PTR_W'(cmt_hit);
    else          tail_d = tail_q + PTR_W'(alloc);
    cmt_d = cmt_q;
    if (cmt_hit) cmt_d[cmt_sel]  = 1'b1;
    if (alloc)   cmt_d[tail_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      cmt_cnt_q <= '0;
      cmt_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cmt_cnt_q <= cmt_cnt_d;
      cmt_q     <= cmt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_q[tail_idx]  <= '{data: lane_place(in_data, in_addr[1:0], in_funct3),
                            mask: byte_mask(in_funct3, in_addr[1:0])};
      word_q[tail_idx] <= in_addr[ADDR_W-1:2];
      tag_q[tail_idx]  <= in_rob_idx;
    end
  end

  sb_fwd_unit #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fwd (
    .ld_valid_i  (in_ld_valid),
    .ld_addr_i   (in_ld_addr),
    .ld_funct3_i (in_ld_funct3),
    .ent_vld_i   (age_vld),
    .ent_word_i  (age_word),
    .ent_data_i  (age_data),
    .ent_mask_i  (age_mask),
    .hit_o       (out_ld_hit),
    .conflict_o  (out_ld_conflict),
    .data_o      (out_ld_data)
  );

endmodule
